// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle main controller: state codes, opcode/funct
// constants, and the datapath select encodings. The jump codes are shared with the
// next-PC unit, so keep them in step with it.
package mc_defs;

    localparam int OP_W = 6;
    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // Instruction classes: each one picks a distinct path through the FSM.
    typedef enum logic [2:0] {
        CL_NOP = 3'd0,   // unsupported encoding, retired as a no-op
        CL_ALU = 3'd1,   // addu, subu, ori, lui
        CL_LW  = 3'd2,
        CL_SW  = 3'd3,
        CL_BEQ = 3'd4,
        CL_J   = 3'd5,
        CL_JR  = 3'd6,
        CL_JAL = 3'd7
    } cls_t;

    // Opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    // Funct codes for R-type (instr[5:0])
    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

    // Next-PC jump select
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;
    localparam logic [1:0] JMP_JAL  = 2'b11;

    // Register-file destination select
    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_LUI  = 2'b11;

    // Static per-instruction control fields, captured once in DECODE.
    typedef struct packed {
        cls_t       cls;
        logic [1:0] alu_op;
        logic       ext_sign;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
    } ctl_t;

    localparam ctl_t CTL_NOP = '{cls: CL_NOP, alu_op: ALU_ADD, ext_sign: 1'b0,
                                 reg_dst: RD_RT, wd_sel: WD_ALU};

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational opcode/funct -> instruction class and static control fields.
// Ports: opcode/funct in; ctl (class, alu_op, ext_sign, reg_dst, wd_sel) and illegal out.
// Purely combinational; no state, no flow control.
module mc_decode
    import mc_defs::*;
(
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    output ctl_t            ctl,
    output logic            illegal
);

    always_comb begin
        ctl     = CTL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        ctl.cls     = CL_ALU;
                        ctl.alu_op  = ALU_ADD;
                        ctl.reg_dst = RD_RD;
                    end
                    FN_SUBU: begin
                        ctl.cls     = CL_ALU;
                        ctl.alu_op  = ALU_SUB;
                        ctl.reg_dst = RD_RD;
                    end
                    FN_JR: begin
                        ctl.cls = CL_JR;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ORI: begin
                ctl.cls    = CL_ALU;
                ctl.alu_op = ALU_OR;
            end
            OP_LUI: begin
                ctl.cls    = CL_ALU;
                ctl.alu_op = ALU_LUI;
            end
            OP_LW: begin
                ctl.cls      = CL_LW;
                ctl.ext_sign = 1'b1;
                ctl.wd_sel   = WD_MEM;
            end
            OP_SW: begin
                ctl.cls      = CL_SW;
                ctl.ext_sign = 1'b1;
            end
            OP_BEQ: begin
                ctl.cls      = CL_BEQ;
                ctl.alu_op   = ALU_SUB;
                ctl.ext_sign = 1'b1;
            end
            OP_J: begin
                ctl.cls = CL_J;
            end
            OP_JAL: begin
                ctl.cls     = CL_JAL;
                ctl.reg_dst = RD_RA;
                ctl.wd_sel  = WD_PC4;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller, IDLE/FETCH/DECODE/EXE/MEM/WB sequencing.
// Ports: clk/rst_n; opcode/funct/zero flags; imem/dmem req/ack handshakes; datapath
// enables (ir_wr, pc_wr, rf_wr, dm_wr), next-PC selects (branch, jump), field selects.
module mc_ctrl
    import mc_defs::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic            zero,
    output logic            imem_req,
    input  logic            imem_ack,
    output logic            dmem_req,
    input  logic            dmem_ack,
    output logic            ir_wr,
    output logic            pc_wr,
    output logic            branch,
    output logic [1:0]      jump,
    output logic            rf_wr,
    output logic            dm_wr,
    output logic [1:0]      reg_dst,
    output logic [1:0]      wd_sel,
    output logic [1:0]      alu_op,
    output logic            ext_sign,
    output logic            illegal
);

    state_t state, state_nxt;
    ctl_t   dec_ctl;
    logic   dec_illegal;
    ctl_t   ctl_q;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .ctl     (dec_ctl),
        .illegal (dec_illegal)
    );

    // The decoded fields are held for the rest of the instruction so the later
    // states do not depend on the IR bus staying stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ctl_q <= CTL_NOP;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                ctl_q <= dec_ctl;
            end
        end
    end

    // All outputs are decoded from the registered state, so an asynchronous reset
    // forces every enable low in the same instant the state returns to IDLE.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        branch    = 1'b0;
        jump      = JMP_NONE;
        rf_wr     = 1'b0;
        dm_wr     = 1'b0;
        reg_dst   = RD_RT;
        wd_sel    = WD_ALU;
        alu_op    = ALU_ADD;
        ext_sign  = 1'b0;
        illegal   = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_wr     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // Unsupported encodings decode to CL_NOP and simply retire in EXE.
                illegal   = dec_illegal;
                state_nxt = S_EXE;
            end
            S_EXE: begin
                alu_op   = ctl_q.alu_op;
                ext_sign = ctl_q.ext_sign;
                case (ctl_q.cls)
                    CL_BEQ: begin
                        branch    = zero;
                        pc_wr     = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    CL_J: begin
                        jump      = JMP_J;
                        pc_wr     = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    CL_JR: begin
                        jump      = JMP_JR;
                        pc_wr     = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    CL_LW, CL_SW: begin
                        state_nxt = S_MEM;
                    end
                    CL_ALU, CL_JAL: begin
                        state_nxt = S_WB;
                    end
                    default: begin
                        pc_wr     = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dm_wr    = (ctl_q.cls == CL_SW);
                if (dmem_ack) begin
                    if (ctl_q.cls == CL_SW) begin
                        pc_wr     = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_wr     = 1'b1;
                pc_wr     = 1'b1;
                reg_dst   = ctl_q.reg_dst;
                wd_sel    = ctl_q.wd_sel;
                jump      = (ctl_q.cls == CL_JAL) ? JMP_JAL : JMP_NONE;
                state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_ack;
    logic       ir_wr;
    logic       pc_wr;
    logic       branch;
    logic [1:0] jump;
    logic       rf_wr;
    logic       dm_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] alu_op;
    logic       ext_sign;
    logic       illegal;

    mc_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .dmem_req (dmem_req),
        .dmem_ack (dmem_ack),
        .ir_wr    (ir_wr),
        .pc_wr    (pc_wr),
        .branch   (branch),
        .jump     (jump),
        .rf_wr    (rf_wr),
        .dm_wr    (dm_wr),
        .reg_dst  (reg_dst),
        .wd_sel   (wd_sel),
        .alu_op   (alu_op),
        .ext_sign (ext_sign),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] all_out;
    assign all_out = {imem_req, dmem_req, ir_wr, pc_wr, branch, jump, rf_wr, dm_wr,
                      reg_dst, wd_sel, alu_op, ext_sign, illegal};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int cycles;
        int br;
        int jmp;
        int rd;
        int wd;
        int alu;
        int ext;
        int rf;
        int dm;
        int ill;
        int viol;
        int ireq;
        int irwr_cyc;
        int dreq;
    } res_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        int         br;
        int         jmp;
        int         rd;
        int         wd;
        int         alu;
        int         ext;
        int         rf;
        int         dm;
        int         ill;
    } vec_t;

    // Runs one instruction starting in FETCH. Inputs change on the falling edge,
    // outputs are sampled 1 time unit later. Ends on the first pc_wr cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int iw, input int dw, input bit stray,
                             output res_t r);
        int  dcnt;
        bit  done;
        dcnt = 0;
        done = 0;
        r = '{default: 0};
        r.cycles = 99;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            opcode = op;
            funct  = fn;
            zero   = z;
            if (dmem_req) dcnt++;
            imem_ack = stray ? 1'b1 : (c == iw + 1);
            dmem_ack = stray ? 1'b1 : (dmem_req && dcnt > dw);
            #1;
            if (imem_req) r.ireq++;
            if (ir_wr)    r.irwr_cyc = c;
            if (dmem_req) r.dreq++;
            if (rf_wr)    r.rf++;
            if (dm_wr)    r.dm++;
            if (illegal)  r.ill++;
            if (!pc_wr && (branch || jump != 2'b00)) r.viol++;
            if (c == iw + 3) begin
                r.alu = alu_op;
                r.ext = ext_sign;
            end
            if (pc_wr) begin
                r.cycles = c;
                r.br  = branch;
                r.jmp = jump;
                r.rd  = reg_dst;
                r.wd  = wd_sel;
                done  = 1;
            end
        end
    endtask

    vec_t vecs[13];
    res_t r;

    initial begin
        //           op         fn         z     cyc br jmp rd wd alu ext rf dm ill
        vecs[0]  = '{6'b000000, 6'b100001, 1'b0, 4, 0, 0, 1, 0, 0, 0, 1, 0, 0}; // addu
        vecs[1]  = '{6'b000000, 6'b100011, 1'b0, 4, 0, 0, 1, 0, 1, 0, 1, 0, 0}; // subu
        vecs[2]  = '{6'b000000, 6'b001000, 1'b0, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0}; // jr
        vecs[3]  = '{6'b001101, 6'b000000, 1'b0, 4, 0, 0, 0, 0, 2, 0, 1, 0, 0}; // ori
        vecs[4]  = '{6'b001111, 6'b000000, 1'b0, 4, 0, 0, 0, 0, 3, 0, 1, 0, 0}; // lui
        vecs[5]  = '{6'b100011, 6'b000000, 1'b0, 5, 0, 0, 0, 1, 0, 1, 1, 0, 0}; // lw
        vecs[6]  = '{6'b101011, 6'b000000, 1'b0, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0}; // sw
        vecs[7]  = '{6'b000100, 6'b000000, 1'b1, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0}; // beq taken
        vecs[8]  = '{6'b000100, 6'b000000, 1'b0, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0}; // beq not taken
        vecs[9]  = '{6'b000010, 6'b000000, 1'b0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0}; // j
        vecs[10] = '{6'b000011, 6'b000000, 1'b0, 4, 0, 3, 2, 2, 0, 0, 1, 0, 0}; // jal
        vecs[11] = '{6'b111111, 6'b000000, 1'b0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1}; // bad opcode
        vecs[12] = '{6'b000000, 6'b111111, 1'b0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1}; // bad funct

        rst_n    = 1'b0;
        opcode   = '0;
        funct    = '0;
        zero     = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        // Reset, then one IDLE cycle, then the fetch request.
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", all_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_after_release", all_out, 0);
        @(negedge clk);
        #1 check("fetch_req_after_idle", imem_req, 1);

        for (int i = 0; i < 13; i++) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, 0, 0, 1'b0, r);
            check($sformatf("v%0d_cycles", i),  r.cycles, vecs[i].cycles);
            check($sformatf("v%0d_branch", i),  r.br,     vecs[i].br);
            check($sformatf("v%0d_jump", i),    r.jmp,    vecs[i].jmp);
            check($sformatf("v%0d_reg_dst", i), r.rd,     vecs[i].rd);
            check($sformatf("v%0d_wd_sel", i),  r.wd,     vecs[i].wd);
            check($sformatf("v%0d_alu_op", i),  r.alu,    vecs[i].alu);
            check($sformatf("v%0d_ext", i),     r.ext,    vecs[i].ext);
            check($sformatf("v%0d_rf_wr", i),   r.rf,     vecs[i].rf);
            check($sformatf("v%0d_dm_wr", i),   r.dm,     vecs[i].dm);
            check($sformatf("v%0d_illegal", i), r.ill,    vecs[i].ill);
            check($sformatf("v%0d_bj_idle", i), r.viol,   0);
        end

        // Fetch wait: ack held off three cycles.
        run_instr(6'b000000, 6'b100001, 1'b0, 3, 0, 1'b0, r);
        check("fwait_cycles",   r.cycles,   7);
        check("fwait_imem_req", r.ireq,     4);
        check("fwait_ir_wr_at", r.irwr_cyc, 4);

        // lw with two data-memory wait cycles.
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, 1'b0, r);
        check("lwwait_cycles",   r.cycles, 7);
        check("lwwait_dmem_req", r.dreq,   3);
        check("lwwait_rf_wr",    r.rf,     1);
        check("lwwait_wd_sel",   r.wd,     1);

        // Both acks held high throughout: acks outside their request state are ignored.
        run_instr(6'b000000, 6'b100011, 1'b0, 0, 0, 1'b1, r);
        check("stray_cycles",   r.cycles, 4);
        check("stray_dmem_req", r.dreq,   0);
        check("stray_rf_wr",    r.rf,     1);

        // Reset asserted mid-cycle while sw is waiting in MEM.
        @(negedge clk);
        opcode   = 6'b101011;
        funct    = 6'b000000;
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sw_mem_dmem_req", dmem_req, 1);
        check("sw_mem_dm_wr",    dm_wr,    1);
        #2 rst_n = 1'b0;
        #1;
        check("sw_rst_dmem_req", dmem_req, 0);
        check("sw_rst_dm_wr",    dm_wr,    0);
        check("sw_rst_all",      all_out,  0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("sw_rst_idle", imem_req, 0);
        run_instr(6'b000000, 6'b100001, 1'b0, 0, 0, 1'b0, r);
        check("restart_cycles", r.cycles, 4);
        check("restart_rf_wr",  r.rf,     1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
